// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector: MAXLEN-bit history, runtime-selectable
// pattern/length, overlapping or restart-on-match modes, saturating match counter.
module seq_detector_param #(
   parameter int unsigned MAXLEN = 8,
   parameter int unsigned CNTW   = 8,
   parameter int unsigned LENW   = 4
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              w,
   input  logic              valid,
   input  logic              clear,
   input  logic [MAXLEN-1:0] pattern,
   input  logic [LENW-1:0]   len,
   input  logic              overlap,
   output logic              z,
   output logic [CNTW-1:0]   count,
   output logic              sat
);

   localparam int unsigned FILLW = $clog2(MAXLEN + 1);

   logic [MAXLEN-1:0] r_hist;
   logic [FILLW-1:0]  r_fill;
   logic [CNTW-1:0]   r_count;
   logic              r_z;

   logic [MAXLEN-1:0] w_hist_next;
   logic [MAXLEN-1:0] w_mask;
   logic [FILLW-1:0]  w_fill_inc;
   logic              w_len_ok;
   logic              w_fill_ok;
   logic              w_eq;
   logic              w_hit;

   // Match is judged on the history/fill as they will be after this sample.
   always_comb begin
      w_hist_next = {r_hist[MAXLEN-2:0], w};
      w_fill_inc  = (32'(r_fill) >= MAXLEN) ? r_fill : r_fill + 1'b1;
      w_mask      = '0;
      for (int unsigned i = 0; i < MAXLEN; i++) begin
         if (i < 32'(len)) begin
            w_mask[i] = 1'b1;
         end
      end
      w_len_ok  = (len != '0) && (32'(len) <= MAXLEN);
      w_fill_ok = 32'(w_fill_inc) >= 32'(len);
      w_eq      = ((w_hist_next ^ pattern) & w_mask) == '0;
      w_hit     = w_len_ok && w_fill_ok && w_eq;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_hist  <= '0;
         r_fill  <= '0;
         r_count <= '0;
         r_z     <= 1'b0;
      end else if (clear) begin
         r_hist  <= '0;
         r_fill  <= '0;
         r_count <= '0;
         r_z     <= 1'b0;
      end else if (valid) begin
         r_hist <= w_hist_next;
         // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
         r_fill <= (w_hit && !overlap) ? '0 : w_fill_inc;
         r_z    <= w_hit;
         if (w_hit && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
         end
      end else begin
         r_z <= 1'b0;
      end
   end

   assign z     = r_z;
   assign count = r_count;
   assign sat   = (r_count == '1);

endmodule
